// File: rtl/axis_packet_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI4-Stream sink between NUM_SRC sources.
// A grant is held until tlast; a beat-limit guard forces termination of runaway packets.
module axis_packet_arbiter #(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned USER_WIDTH = 4,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned MAX_BEATS  = 256,
  localparam int unsigned GW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int unsigned KW = DATA_WIDTH / 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           arb_en,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [NUM_SRC*KW-1:0]          s_axis_tkeep,
  input  logic [NUM_SRC-1:0]             s_axis_tlast,
  input  logic [NUM_SRC*USER_WIDTH-1:0]  s_axis_tuser,
  input  logic [NUM_SRC*ID_WIDTH-1:0]    s_axis_tid,
  input  logic [NUM_SRC-1:0]             s_axis_tvalid,
  output logic [NUM_SRC-1:0]             s_axis_tready,
  output logic [DATA_WIDTH-1:0]          m_axis_tdata,
  output logic [KW-1:0]                  m_axis_tkeep,
  output logic                           m_axis_tlast,
  output logic [USER_WIDTH-1:0]          m_axis_tuser,
  output logic [ID_WIDTH-1:0]            m_axis_tid,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           busy,
  output logic [GW-1:0]                  grant_idx,
  output logic                           err_overlong
);

  localparam int unsigned CW = $clog2(MAX_BEATS + 1);

  typedef enum logic [0:0] {StIdle, StXfer} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic [GW-1:0] cand [NUM_SRC];
  logic [GW-1:0] pick;
  logic          pick_vld;
  logic          src_last;
  logic          at_limit;

  // Candidate order starts just after the last granted source and wraps.
  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      cand[i] = GW'((32'(last_q) + i + 1) % NUM_SRC);
    end
  end

  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (!pick_vld && s_axis_tvalid[cand[i]]) begin
        pick_vld = 1'b1;
        pick     = cand[i];
      end
    end
  end

  assign src_last = s_axis_tlast[grant_q];
  // The beat being offered is the MAX_BEATS-th of this grant.
  assign at_limit = (cnt_q == CW'(MAX_BEATS - 1));

  assign m_axis_tdata = s_axis_tdata[32'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
  assign m_axis_tkeep = s_axis_tkeep[32'(grant_q) * KW +: KW];
  assign m_axis_tuser = s_axis_tuser[32'(grant_q) * USER_WIDTH +: USER_WIDTH];
  assign m_axis_tid   = s_axis_tid[32'(grant_q) * ID_WIDTH +: ID_WIDTH];

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    s_axis_tready = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arb_en && pick_vld) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = StXfer;
        end
      end
      StXfer: begin
        s_axis_tready[grant_q] = m_axis_tready;
        m_axis_tvalid          = s_axis_tvalid[grant_q];
        m_axis_tlast           = src_last | at_limit;
        if (m_axis_tvalid && m_axis_tready) begin
          // Cannot wrap: the grant always ends on the MAX_BEATS-th beat.
          cnt_d = cnt_q + 1'b1;
          if (m_axis_tlast) begin
            last_d  = grant_q;
            state_d = StIdle;
            if (at_limit && !src_last) begin
              err_d = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= GW'(NUM_SRC - 1);
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign busy         = (state_q == StXfer);
  assign grant_idx    = grant_q;
  assign err_overlong = err_q;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Self-checking bench for axis_packet_arbiter: directed scenarios plus randomized
// packet traffic scored against a packet-level round-robin reference model.
module tb_axis_packet_arbiter;

  localparam int unsigned NS   = 4;
  localparam int unsigned DW   = 32;
  localparam int unsigned UW   = 4;
  localparam int unsigned IW   = 4;
  localparam int unsigned MB   = 4;
  localparam int unsigned KW   = DW / 8;
  localparam int unsigned MAXB = 32;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               arb_en;
  logic [NS*DW-1:0]   s_tdata;
  logic [NS*KW-1:0]   s_tkeep;
  logic [NS-1:0]      s_tlast;
  logic [NS*UW-1:0]   s_tuser;
  logic [NS*IW-1:0]   s_tid;
  logic [NS-1:0]      s_tvalid;
  logic [NS-1:0]      s_tready;
  logic [DW-1:0]      m_tdata;
  logic [KW-1:0]      m_tkeep;
  logic               m_tlast;
  logic [UW-1:0]      m_tuser;
  logic [IW-1:0]      m_tid;
  logic               m_tvalid;
  logic               m_tready;
  logic               busy;
  logic [1:0]         grant_idx;
  logic               err_overlong;

  axis_packet_arbiter #(
    .NUM_SRC(NS), .DATA_WIDTH(DW), .USER_WIDTH(UW), .ID_WIDTH(IW), .MAX_BEATS(MB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .s_axis_tuser(s_tuser), .s_axis_tid(s_tid), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
    .m_axis_tuser(m_tuser), .m_axis_tid(m_tid), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .busy(busy), .grant_idx(grant_idx), .err_overlong(err_overlong)
  );

  always #5 clk = ~clk;

  // Per-source beat lists; each source presents beats in order, valid while any remain.
  logic [DW-1:0] bd [NS][MAXB];
  logic          bl [NS][MAXB];
  int            nb [NS];
  int            ptr [NS];
  logic          src_on [NS];
  logic          fire [NS];
  logic          rdy, en;
  int            cycle = 0;

  logic [DW-1:0] o_data [$];
  int            o_src [$];
  logic          o_last [$];
  int            o_cyc [$];

  logic [DW-1:0] e_data [$];
  int            e_src [$];
  logic          e_last [$];
  logic          e_err;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    s_tvalid = '0; s_tdata = '0; s_tlast = '0; s_tkeep = '0; s_tuser = '0;
    for (int s = 0; s < NS; s++) begin
      s_tid[s*IW +: IW] = IW'(s);
      if (src_on[s] && ptr[s] < nb[s]) begin
        s_tvalid[s]         = 1'b1;
        s_tdata[s*DW +: DW] = bd[s][ptr[s]];
        s_tlast[s]          = bl[s][ptr[s]];
        s_tkeep[s*KW +: KW] = bd[s][ptr[s]][KW-1:0];
        s_tuser[s*UW +: UW] = bd[s][ptr[s]][7:4];
      end
    end
  endtask

  // One clock: apply inputs after the edge, sample and log at the falling edge.
  task automatic cyc();
    @(posedge clk); #1;
    for (int s = 0; s < NS; s++) if (fire[s]) ptr[s]++;
    m_tready = rdy;
    arb_en   = en;
    drive();
    cycle++;
    @(negedge clk);
    for (int s = 0; s < NS; s++) fire[s] = s_tvalid[s] && s_tready[s];
    chk("tready_onehot", 32'($countones(s_tready) <= 1), 1);
    if (m_tvalid && m_tready) begin
      o_data.push_back(m_tdata);
      o_src.push_back(int'(grant_idx));
      o_last.push_back(m_tlast);
      o_cyc.push_back(cycle);
      chk("beat_keep", m_tkeep, m_tdata[KW-1:0]);
      chk("beat_user", m_tuser, m_tdata[7:4]);
      chk("beat_tid", m_tid, grant_idx);
    end
  endtask

  task automatic clear_srcs();
    for (int s = 0; s < NS; s++) begin
      ptr[s] = 0; nb[s] = 0; fire[s] = 1'b0; src_on[s] = 1'b0;
    end
    o_data.delete(); o_src.delete(); o_last.delete(); o_cyc.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_srcs();
    drive();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic add_pkt(input int s, input int len, input logic [DW-1:0] base);
    for (int b = 0; b < len; b++) begin
      bd[s][nb[s]] = base + DW'(b);
      bl[s][nb[s]] = (b == len - 1);
      nb[s]++;
    end
  endtask

  task automatic run_until(input int n, input int bound);
    int k = 0;
    while (o_data.size() < n && k < bound) begin
      cyc();
      k++;
    end
    if (o_data.size() < n) chk("timeout", o_data.size(), n);
  endtask

  // Reference: packets served whole in round-robin order among sources holding data,
  // each grant cut after MB beats with the remainder re-queued as a fresh packet.
  task automatic build_model();
    int h [NS];
    int lastg = NS - 1;
    int s;
    logic fl;
    e_data.delete(); e_src.delete(); e_last.delete();
    e_err = 1'b0;
    for (int i = 0; i < NS; i++) h[i] = 0;
    forever begin
      s = -1;
      for (int i = 1; i <= NS; i++) begin
        if (s < 0 && h[(lastg + i) % NS] < nb[(lastg + i) % NS]) s = (lastg + i) % NS;
      end
      if (s < 0) break;
      for (int n = 0; n < MB; n++) begin
        fl = bl[s][h[s]] || (n == MB - 1);
        if (n == MB - 1 && !bl[s][h[s]]) e_err = 1'b1;
        e_data.push_back(bd[s][h[s]]);
        e_src.push_back(s);
        e_last.push_back(fl);
        h[s]++;
        if (fl) break;
      end
      lastg = s;
    end
  endtask

  initial begin
    rdy = 1'b1; en = 1'b1; m_tready = 1'b1; arb_en = 1'b1;
    s_tid = '0;
    clear_srcs();
    drive();

    // Single 3-beat packet from source 1
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_idx, 0);
    chk("rst_err", err_overlong, 0);
    add_pkt(1, 3, 32'hA);
    src_on[1] = 1'b1;
    cyc();
    chk("t1_idle_valid", m_tvalid, 0);
    chk("t1_idle_tready", s_tready, 0);
    cyc();
    chk("t1_grant", grant_idx, 1);
    chk("t1_b1_valid", m_tvalid, 1);
    chk("t1_b1_data", m_tdata, 32'hA);
    chk("t1_tready", s_tready, 4'b0010);
    chk("t1_busy", busy, 1);
    cyc();
    chk("t1_b2_data", m_tdata, 32'hB);
    chk("t1_b2_last", m_tlast, 0);
    cyc();
    chk("t1_b3_data", m_tdata, 32'hC);
    chk("t1_b3_last", m_tlast, 1);
    cyc();
    chk("t1_end_busy", busy, 0);
    chk("t1_end_valid", m_tvalid, 0);
    chk("t1_end_tready", s_tready, 0);
    chk("t1_end_grant", grant_idx, 1);

    // All sources continuously valid with 2-beat packets
    do_reset();
    for (int s = 0; s < NS; s++) begin
      add_pkt(s, 2, 32'h100 * s);
      add_pkt(s, 2, 32'h100 * s + 32'h10);
      src_on[s] = 1'b1;
    end
    run_until(16, 100);
    for (int k = 0; k < o_data.size(); k++) begin
      chk("t2_src", o_src[k], (k / 2) % NS);
      chk("t2_data", o_data[k], 32'h100 * ((k / 2) % NS) + 32'h10 * (k / 8) + (k % 2));
      if (k > 0) chk("t2_gap", o_cyc[k] - o_cyc[k-1], (k % 2 == 0) ? 2 : 1);
    end

    // Backpressure mid-packet on source 2
    do_reset();
    add_pkt(2, 4, 32'h20);
    src_on[2] = 1'b1;
    run_until(2, 20);
    rdy = 1'b0;
    repeat (3) begin
      cyc();
      chk("t3_stall_tready", s_tready, 0);
      chk("t3_stall_valid", m_tvalid, 1);
      chk("t3_stall_data", m_tdata, 32'h22);
    end
    rdy = 1'b1;
    run_until(4, 20);
    repeat (3) cyc();
    chk("t3_count", o_data.size(), 4);
    for (int k = 0; k < o_data.size(); k++) begin
      chk("t3_data", o_data[k], 32'h20 + k);
      chk("t3_last", o_last[k], k == 3);
    end
    chk("t3_err", err_overlong, 0);

    // arb_en dropped mid-packet
    do_reset();
    add_pkt(3, 3, 32'h30);
    add_pkt(0, 1, 32'h40);
    add_pkt(1, 1, 32'h50);
    src_on[3] = 1'b1;
    run_until(1, 20);
    src_on[0] = 1'b1; src_on[1] = 1'b1; en = 1'b0;
    cyc();
    chk("t5_busy_during", busy, 1);
    run_until(3, 20);
    for (int k = 0; k < o_src.size(); k++) chk("t5_src", o_src[k], 3);
    repeat (4) begin
      cyc();
      chk("t5_hold_busy", busy, 0);
      chk("t5_hold_valid", m_tvalid, 0);
      chk("t5_hold_tready", s_tready, 0);
    end
    en = 1'b1;
    cyc();
    chk("t5_arb_valid", m_tvalid, 0);
    cyc();
    chk("t5_grant", grant_idx, 0);
    chk("t5_valid", m_tvalid, 1);
    chk("t5_data", m_tdata, 32'h40);

    // Overlong packet: 6 beats with MB=4, source 1 pending
    do_reset();
    add_pkt(0, 6, 32'h60);
    add_pkt(1, 1, 32'h70);
    src_on[0] = 1'b1; src_on[1] = 1'b1;
    run_until(3, 20);
    chk("t4_err_early", err_overlong, 0);
    run_until(7, 40);
    begin
      int exp_src [7]       = '{0, 0, 0, 0, 1, 0, 0};
      logic exp_last [7]    = '{0, 0, 0, 1, 1, 0, 1};
      logic [31:0] exp_d [7] = '{32'h60, 32'h61, 32'h62, 32'h63, 32'h70, 32'h64, 32'h65};
      for (int k = 0; k < o_data.size() && k < 7; k++) begin
        chk("t4_src", o_src[k], exp_src[k]);
        chk("t4_last", o_last[k], exp_last[k]);
        chk("t4_data", o_data[k], exp_d[k]);
      end
    end
    chk("t4_gap", o_cyc[4] - o_cyc[3], 2);
    chk("t4_err", err_overlong, 1);
    repeat (3) cyc();
    chk("t4_err_sticky", err_overlong, 1);

    // Reset mid-packet
    o_data.delete(); o_src.delete(); o_last.delete(); o_cyc.delete();
    add_pkt(0, 5, 32'h80);
    run_until(1, 20);
    cyc();
    chk("t6_b2_data", m_tdata, 32'h81);
    chk("t6_b2_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_tready", s_tready, 0);
    chk("t6_rst_valid", m_tvalid, 0);
    chk("t6_rst_err", err_overlong, 0);
    chk("t6_rst_busy", busy, 0);
    clear_srcs();
    add_pkt(2, 1, 32'h90);
    add_pkt(0, 1, 32'hA0);
    src_on[0] = 1'b1; src_on[2] = 1'b1;
    drive();
    @(negedge clk);
    rst_n = 1'b1;
    run_until(2, 20);
    chk("t6_first_src", o_src[0], 0);
    chk("t6_first_data", o_data[0], 32'hA0);
    chk("t6_second_src", o_src[1], 2);

    // Randomized traffic with random sink backpressure
    for (int r = 0; r < 3; r++) begin
      int k;
      do_reset();
      for (int s = 0; s < NS; s++) begin
        repeat (3) add_pkt(s, $urandom_range(1, 6), DW'($urandom));
        src_on[s] = 1'b1;
      end
      build_model();
      k = 0;
      while (o_data.size() < e_data.size() && k < 3000) begin
        rdy = ($urandom_range(0, 3) != 0);
        cyc();
        k++;
      end
      rdy = 1'b1;
      repeat (3) cyc();
      chk("rnd_count", o_data.size(), e_data.size());
      for (int j = 0; j < o_data.size() && j < e_data.size(); j++) begin
        chk("rnd_data", o_data[j], e_data[j]);
        chk("rnd_src", o_src[j], e_src[j]);
        chk("rnd_last", o_last[j], e_last[j]);
        if (j > 0 && e_last[j-1]) chk("rnd_bubble", 32'(o_cyc[j] - o_cyc[j-1] >= 2), 1);
      end
      chk("rnd_err", err_overlong, e_err);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axis_packet_arbiter.md
Name: axis_packet_arbiter

Overview:
- Packet-level round-robin arbiter that shares one AXI4-Stream sink, such as the NPU stream ingress FIFO, between NUM_SRC AXI4-Stream sources.
- A grant is held for the whole packet, up to tlast, so beats from different sources never interleave.
- Includes an overlong-packet guard, so one source missing tlast cannot lock the sink.
- Sits between DMA/engine stream producers and the shared stream sink.

Parameters:
- NUM_SRC, 4, number of source ports (2..16).
- DATA_WIDTH, 128, tdata width in bits (multiple of 8).
- USER_WIDTH, 4, tuser width.
- ID_WIDTH, 4, tid width.
- MAX_BEATS, 256, beat limit per granted packet before forced termination (≥2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- arb_en  in  1  1 = new grants allowed; 0 = finish current packet, then stop granting.
- s_axis_tdata  in  NUM_SRC*DATA_WIDTH  source i at [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tkeep  in  NUM_SRC*DATA_WIDTH/8  per-source tkeep, same packing.
- s_axis_tlast  in  NUM_SRC  per-source tlast.
- s_axis_tuser  in  NUM_SRC*USER_WIDTH  per-source tuser.
- s_axis_tid  in  NUM_SRC*ID_WIDTH  per-source tid.
- s_axis_tvalid  in  NUM_SRC  per-source tvalid.
- s_axis_tready  out  NUM_SRC  per-source tready.
- m_axis_tdata  out  DATA_WIDTH  muxed data.
- m_axis_tkeep  out  DATA_WIDTH/8  muxed tkeep.
- m_axis_tlast  out  1  muxed tlast, or forced by the guard.
- m_axis_tuser  out  USER_WIDTH  muxed tuser.
- m_axis_tid  out  ID_WIDTH  muxed tid, passed through unchanged.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  sink ready.
- busy  out  1  1 while in XFER.
- grant_idx  out  max(1,$clog2(NUM_SRC))  currently or last granted source.
- err_overlong  out  1  sticky; set on forced termination, cleared only by reset.

Behaviour:

FSM states and transitions:
- IDLE: no s_axis_tready asserted and m_axis_tvalid=0.
  - If arb_en=1 and any s_axis_tvalid is 1, pick the first valid source searching from (last_grant+1) mod NUM_SRC upward with wrap.
  - Register that source into grant_idx and go to XFER.
  - Clear the beat counter.
- XFER: combinational pass-through from the granted source only.
  - m_axis_tvalid = s_axis_tvalid[grant_idx]; payload = granted source's fields.
  - s_axis_tready[grant_idx] = m_axis_tready; all other tready = 0.
  - A beat is counted on each m_axis_tvalid&&m_axis_tready.
  - On a beat with m_axis_tlast=1: last_grant <= grant_idx, go to IDLE.

Timing:
- Arbitration costs exactly one bubble cycle per packet: a valid present in an IDLE cycle gives its first beat, on m_axis, in the next cycle at the earliest.
- Back-to-back packets from any sources therefore see 1 idle cycle between them.

Overlong guard:
- The beat counter is $clog2(MAX_BEATS+1) bits wide.
- On the MAX_BEATS-th beat of a grant, if the source tlast is 0, force m_axis_tlast=1 on that beat and set err_overlong.
- That beat ends the grant (go to IDLE, update last_grant).
- The source's remaining beats re-arbitrate as a new packet.
- The counter never wraps.

Control and flow rules:
- arb_en: deasserting in XFER does not abort the packet; it only blocks the IDLE→XFER transition.
- Source valid dropping mid-packet (a protocol violation): hold the grant; m_axis_tvalid follows the source.
- Sink backpressure: outputs follow the granted source combinationally; no data is held internally.
- Valid holds under backpressure by source-side AXI rules.
- Fairness: with all sources continuously valid, grants rotate 0,1,...,NUM_SRC-1,0. A source that is not valid is skipped with no cycle penalty.

Reset, including mid-packet:
- State goes to IDLE; last_grant = NUM_SRC-1, so source 0 wins first; grant_idx = 0.
- busy = 0, err_overlong = 0, beat counter = 0.
- All s_axis_tready = 0; m_axis_tvalid = 0.
- An in-flight packet is abandoned; the next grant after reset is a fresh packet.

Test Plan:
1. Single source 1 sends a 3-beat packet (tdata 0xA,0xB,0xC; tlast on beat 3) with m_axis_tready=1 → grant_idx=1; beats appear on cycles 2,3,4 after tvalid rises; busy drops after beat 3; other tready remain 0 throughout.
2. All 4 sources continuously valid with 2-beat packets → output source order 0,0,1,1,2,2,3,3,0,0; exactly 1 idle cycle between packets; no interleaving.
3. Source 2 sends a 4-beat packet; m_axis_tready=0 for 3 cycles after beat 2 → s_axis_tready[2]=0 during the stall; beats 3-4 are delivered unchanged; no beat is lost or duplicated.
4. MAX_BEATS=4; source 0 sends 6 beats with tlast only on beat 6 → m_axis_tlast=1 on beat 4; err_overlong=1 and stays 1; beats 5-6 go out as a separate grant after 1 bubble (or after other pending sources in RR order).
5. arb_en driven 0 during beat 2 of a 3-beat packet from source 3, with sources 0 and 1 valid → packet completes; busy=0 and no new grant while arb_en=0; arb_en=1 → source 0 granted next.
6. rst_n asserted mid-packet (beat 2 of 5) → immediately all tready=0, m_axis_tvalid=0, err_overlong=0; after release with sources 0 and 2 valid, source 0 is granted first.
